// File: rtl/kitchen_responder.sv
// Game-side responder for the controller command/status link: decodes command bytes,
// models the kitchen (player position, held item, occupancy, machine processing) and returns a status byte.
module kitchen_responder #(
  parameter int MOVE_CYCLES    = 16,
  parameter int PROCESS_CYCLES = 64,
  parameter int NUM_TARGETS    = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_bits,
  output logic [7:0] out_bits,
  output logic [4:0] cur_target,
  output logic       busy
);

  localparam int MW = $clog2(MOVE_CYCLES + 1);
  localparam int PW = $clog2(PROCESS_CYCLES + 1);
  localparam logic [MW-1:0] MV_LOAD = MW'(MOVE_CYCLES);
  localparam logic [MW-1:0] MV_ONE  = MW'(1);
  localparam logic [PW-1:0] PR_LOAD = PW'(PROCESS_CYCLES);
  localparam logic [PW-1:0] PR_ONE  = PW'(1);
  localparam logic [5:0]    MAX_SEL = 6'(NUM_TARGETS);

  typedef enum logic {ST_STOPPED = 1'b0, ST_RUNNING = 1'b1} run_t;

  run_t                 state, state_nx;
  logic [7:0]           prev_in;
  logic [4:0]           sel_target, sel_nx;
  logic [4:0]           cur_nx, mv_dest, mv_dest_nx, proc_id, proc_id_nx;
  logic [MW-1:0]        mv_cnt, mv_nx;
  logic [PW-1:0]        pr_cnt, pr_nx;
  logic                 holding, holding_nx;
  logic [NUM_TARGETS:0] occ, occ_nx;
  logic [7:0]           out_nx;

  logic       fresh;
  logic [5:0] arg;
  logic       cmd_start, cmd_stop, is_op;
  logic       at_now, proc_now, occ_now, t_disp, t_bin, t_store, t_throw;
  logic       at_nx, proc_bit, occ_bit;

  function automatic logic f_disp(input logic [4:0] t);
    return (t >= 5'd1) && (t <= 5'd6);
  endfunction

  function automatic logic f_store(input logic [4:0] t);
    return (t >= 5'd7) && (t <= MAX_SEL[4:0]) && (t != 5'd18);
  endfunction

  // Control and operation bytes act only on the first cycle they appear.
  assign fresh     = (in_bits != prev_in);
  assign arg       = in_bits[7:2];
  assign cmd_start = fresh && (in_bits[1:0] == 2'b01) && (arg == 6'b000001);
  assign cmd_stop  = fresh && (in_bits[1:0] == 2'b01) && (arg == 6'b000010);
  assign is_op     = fresh && (in_bits[1:0] == 2'b10);

  assign t_disp  = f_disp(sel_target);
  assign t_bin   = (sel_target == 5'd18);
  assign t_store = f_store(sel_target);
  assign t_throw = (sel_target == 5'd9)  || (sel_target == 5'd11) || (sel_target == 5'd14) ||
                   (sel_target == 5'd17) || (sel_target == 5'd19) || (sel_target == 5'd20);

  always_comb begin
    state_nx   = state;
    sel_nx     = sel_target;
    cur_nx     = cur_target;
    mv_nx      = mv_cnt;
    mv_dest_nx = mv_dest;
    pr_nx      = pr_cnt;
    proc_id_nx = proc_id;
    holding_nx = holding;
    occ_nx     = occ;
    at_now     = 1'b0;
    proc_now   = 1'b0;
    occ_now    = 1'b0;

    if (state == ST_STOPPED) begin
      if (cmd_start) begin
        state_nx   = ST_RUNNING;
        cur_nx     = '0;
        mv_nx      = '0;
        pr_nx      = '0;
        holding_nx = 1'b0;
        occ_nx     = '0;
      end
    end else if (cmd_stop) begin
      state_nx = ST_STOPPED;
    end else begin
      // Counter expiry lands before this cycle's command is evaluated.
      if (mv_cnt != '0) begin
        mv_nx = mv_cnt - MV_ONE;
        if (mv_cnt == MV_ONE) cur_nx = mv_dest;
      end
      if (pr_cnt != '0) pr_nx = pr_cnt - PR_ONE;

      at_now   = (cur_nx != 5'd0) && (cur_nx == sel_target) && (mv_nx == '0);
      proc_now = (pr_nx != '0) && (proc_id == sel_target);
      occ_now  = occ[sel_target];

      if (in_bits[1:0] == 2'b11)
        sel_nx = ((arg == 6'd0) || (arg > MAX_SEL)) ? 5'd0 : arg[4:0];

      if (is_op) begin
        case (arg)
          6'b000001: if (at_now && !holding && !proc_now && (t_disp || (t_store && occ_now))) begin
            holding_nx = 1'b1;
            if (t_store) occ_nx[sel_target] = 1'b0;
          end
          6'b000010: if (at_now && holding && (t_disp || t_bin || (t_store && !occ_now))) begin
            holding_nx = 1'b0;
            if (t_store) occ_nx[sel_target] = 1'b1;
          end
          6'b000100: if (at_now && t_store && occ_now && (pr_nx == '0)) begin
            pr_nx      = PR_LOAD;
            proc_id_nx = sel_target;
          end
          6'b001000: if (sel_target != 5'd0) begin
            cur_nx     = 5'd0;
            mv_nx      = MV_LOAD;
            mv_dest_nx = sel_target;
          end
          6'b010000: if (holding && at_now && t_throw) holding_nx = 1'b0;
          default: ;
        endcase
      end
    end

    at_nx    = (cur_nx != 5'd0) && (cur_nx == sel_nx) && (mv_nx == '0);
    proc_bit = (pr_nx != '0) && (proc_id_nx == sel_nx);
    occ_bit  = f_disp(sel_nx) || (f_store(sel_nx) && occ_nx[sel_nx]);
    out_nx   = {2'b00, occ_bit, proc_bit, holding_nx, at_nx, 1'b0, state_nx == ST_RUNNING};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_STOPPED;
      prev_in    <= '0;
      sel_target <= '0;
      cur_target <= '0;
      mv_cnt     <= '0;
      mv_dest    <= '0;
      pr_cnt     <= '0;
      proc_id    <= '0;
      holding    <= 1'b0;
      occ        <= '0;
      out_bits   <= '0;
    end else begin
      state      <= state_nx;
      prev_in    <= in_bits;
      sel_target <= sel_nx;
      cur_target <= cur_nx;
      mv_cnt     <= mv_nx;
      mv_dest    <= mv_dest_nx;
      pr_cnt     <= pr_nx;
      proc_id    <= proc_id_nx;
      holding    <= holding_nx;
      occ        <= occ_nx;
      out_bits   <= out_nx;
    end
  end

  assign busy = (mv_cnt != '0) || (pr_cnt != '0);

endmodule

// File: tb/tb_kitchen_responder.sv
// Bench for kitchen_responder: directed walk through the kitchen flows with literal checks,
// then random command traffic compared every cycle against a behavioural kitchen model.
module tb_kitchen_responder;

  localparam int MC = 16;
  localparam int PC = 64;
  localparam int NT = 20;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_bits;
  logic [7:0] out_bits;
  logic [4:0] cur_target;
  logic       busy;

  kitchen_responder #(.MOVE_CYCLES(MC), .PROCESS_CYCLES(PC), .NUM_TARGETS(NT)) dut (
    .clk(clk), .rst_n(rst_n), .in_bits(in_bits),
    .out_bits(out_bits), .cur_target(cur_target), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [13:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural kitchen model ----------------
  int m_run, m_sel, m_cur, m_mv, m_dest, m_hold, m_pr, m_ptgt;
  bit m_occ[0:31];
  logic [7:0] m_prev;

  function automatic bit is_disp(input int t); return t >= 1 && t <= 6; endfunction
  function automatic bit is_bin(input int t); return t == 18; endfunction
  function automatic bit is_store(input int t); return t >= 7 && t <= NT && t != 18; endfunction

  function automatic bit m_at();
    return m_cur != 0 && m_cur == m_sel && m_mv == 0;
  endfunction

  task automatic model_reset();
    m_run = 0; m_sel = 0; m_cur = 0; m_mv = 0; m_dest = 0;
    m_hold = 0; m_pr = 0; m_ptgt = 0; m_prev = 8'h00;
    foreach (m_occ[i]) m_occ[i] = 0;
  endtask

  task automatic model_step(input logic [7:0] b);
    bit fresh;
    int kind, arg;
    fresh  = (b != m_prev);
    m_prev = b;
    kind   = int'(b[1:0]);
    arg    = int'(b[7:2]);
    if (m_run == 0) begin
      if (fresh && kind == 1 && arg == 1) begin
        m_run = 1; m_hold = 0; m_cur = 0; m_mv = 0; m_pr = 0;
        foreach (m_occ[i]) m_occ[i] = 0;
      end
    end else if (fresh && kind == 1 && arg == 2) begin
      m_run = 0;
    end else begin
      if (m_mv > 0) begin
        m_mv--;
        if (m_mv == 0) m_cur = m_dest;
      end
      if (m_pr > 0) m_pr--;
      if (kind == 3) m_sel = (arg >= 1 && arg <= NT) ? arg : 0;
      else if (kind == 2 && fresh) begin
        case (arg)
          1: if (m_at() && m_hold == 0 && !(m_pr > 0 && m_ptgt == m_sel) &&
                 (is_disp(m_sel) || (is_store(m_sel) && m_occ[m_sel]))) begin
               m_hold = 1;
               if (is_store(m_sel)) m_occ[m_sel] = 0;
             end
          2: if (m_at() && m_hold == 1 &&
                 (is_disp(m_sel) || is_bin(m_sel) || (is_store(m_sel) && !m_occ[m_sel]))) begin
               m_hold = 0;
               if (is_store(m_sel)) m_occ[m_sel] = 1;
             end
          4: if (m_at() && is_store(m_sel) && m_occ[m_sel] && m_pr == 0) begin
               m_pr = PC; m_ptgt = m_sel;
             end
          8: if (m_sel != 0) begin
               m_cur = 0; m_mv = MC; m_dest = m_sel;
             end
          16: if (m_hold == 1 && m_at() && (m_sel inside {9, 11, 14, 17, 19, 20})) m_hold = 0;
          default: ;
        endcase
      end
    end
  endtask

  function automatic logic [13:0] model_status();
    logic [7:0] o;
    logic       bz;
    o    = 8'h00;
    o[0] = (m_run != 0);
    o[2] = m_at();
    o[3] = (m_hold != 0);
    o[4] = (m_pr > 0 && m_ptgt == m_sel);
    o[5] = is_disp(m_sel) || (is_store(m_sel) && m_occ[m_sel]);
    bz   = (m_mv > 0) || (m_pr > 0);
    return {bz, 5'(m_cur), o};
  endfunction

  initial model_reset();

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else model_step(in_bits);
    exp_q.push_back(model_status());
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) check("status{busy,cur,out}", {18'd0, busy, cur_target, out_bits}, {18'd0, exp_q.pop_front()});
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] b, input int n);
    repeat (n) begin
      in_bits = b;
      @(negedge clk);
    end
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    in_bits = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_out", {24'd0, out_bits}, 32'h00);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_cur", {27'd0, cur_target}, 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic rand_phase(input int n);
    int r, k, hold;
    logic [5:0] a;
    logic [7:0] b;
    for (int t = 0; t < n; t++) begin
      r    = $urandom_range(0, 99);
      hold = $urandom_range(1, 4);
      if (r < 25) begin
        a = 6'($urandom_range(0, 23));
        b = {a, 2'b11};
      end else if (r < 60) begin
        k = $urandom_range(0, 4);
        a = 6'(1 << k);
        b = {a, 2'b10};
        if (k == 3) hold = $urandom_range(1, 24);
      end else if (r < 65) begin
        a = 6'($urandom_range(0, 63));
        b = {a, 2'b10};
      end else if (r < 71) begin
        b = 8'h05;
      end else if (r < 73) begin
        b = 8'h09;
      end else if (r < 76) begin
        b = 8'($urandom_range(0, 255));
      end else begin
        b = 8'h00;
      end
      send(b, hold);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst_n   = 1'b0;
    in_bits = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_out", {24'd0, out_bits}, 32'h00);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // start, then hold the start byte
    send(8'h05, 1);  check("start", {24'd0, out_bits}, 32'h01);
    send(8'h05, 10); check("start_held", {24'd0, out_bits}, 32'h01);

    // move to dispenser 3 and take an item
    send(8'h0F, 1);
    send(8'h22, 1);  check("move_busy", {31'd0, busy}, 32'd1);
    send(8'h22, MC - 1); check("move_in_flight", {31'd0, out_bits[2]}, 32'd0);
    send(8'h22, 1);  check("arrive_3", {24'd0, out_bits}, 32'h25);
    check("cur_3", {27'd0, cur_target}, 32'd3);
    send(8'h06, 1);  check("get_disp", {24'd0, out_bits}, 32'h2D);

    // put into storage 7, process, refused get, get after expiry
    send(8'h1F, 1);  check("sel_7", {24'd0, out_bits}, 32'h09);
    send(8'h22, MC + 1); check("arrive_7", {24'd0, out_bits}, 32'h0D);
    send(8'h0A, 1);  check("put_7", {24'd0, out_bits}, 32'h25);
    send(8'h12, 1);  check("interact", {24'd0, out_bits}, 32'h35);
    send(8'h12, 10);
    send(8'h06, 1);  check("get_refused", {24'd0, out_bits}, 32'h35);
    send(8'h00, 52); check("process_last", {24'd0, out_bits}, 32'h35);
    send(8'h00, 1);  check("process_done", {24'd0, out_bits}, 32'h25);
    send(8'h06, 1);  check("get_after", {24'd0, out_bits}, 32'h0D);

    // throw at 9 succeeds, at 10 is ignored
    send(8'h27, 1);
    send(8'h22, MC + 1); check("arrive_9", {24'd0, out_bits}, 32'h0D);
    send(8'h42, 1);  check("throw_9", {24'd0, out_bits}, 32'h05);
    send(8'h07, 1);
    send(8'h22, MC + 1);
    send(8'h06, 1);  check("get_disp1", {24'd0, out_bits}, 32'h2D);
    send(8'h2B, 1);
    send(8'h22, MC + 1);
    send(8'h42, 1);  check("throw_10", {24'd0, out_bits}, 32'h0D);
    send(8'h0A, 1);  check("put_10", {24'd0, out_bits}, 32'h25);

    // stop mid-move, ignored commands, restart clears
    send(8'h33, 1);
    send(8'h22, 5);
    send(8'h09, 1);  check("stop_out", {24'd0, out_bits}, 32'h00);
    check("stop_busy_frozen", {31'd0, busy}, 32'd1);
    send(8'h06, 2); send(8'h22, 2); send(8'h0F, 2); send(8'h00, 3);
    check("stopped_ignore", {24'd0, out_bits}, 32'h00);
    check("stopped_cur", {27'd0, cur_target}, 32'd0);
    send(8'h05, 1);  check("restart", {24'd0, out_bits}, 32'h01);
    check("restart_busy", {31'd0, busy}, 32'd0);
    send(8'h2B, 1);  check("occ_cleared", {24'd0, out_bits}, 32'h01);

    // invalid select, ignored move, non-one-hot op
    send(8'h67, 1);  check("sel_25", {24'd0, out_bits}, 32'h01);
    send(8'h22, 1);  check("move_invalid", {31'd0, busy}, 32'd0);
    send(8'h0E, 1);  check("op_two_hot", {24'd0, out_bits}, 32'h01);

    // reset mid-move aborts
    send(8'h0F, 1);
    send(8'h22, 3);
    pulse_reset();

    rand_phase(1200);
    send(8'h00, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
